lbdr_param: RTL and testbench

// - Parametrised Logic-Based Distributed Routing unit, one per NoC router input port; successor to fixed 4-bit LBDR.
// - Computes N/E/W/S/L output-port requests from the input FIFO head flit and holds them for the whole packet.
// - Generalised mesh coordinate widths; route held until tail flit is popped (flit_rd handshake).
// - Run-time reconfiguration of Rxy/Cx, applied only between packets.

---
 rtl/lbdr_param.sv | 158 +++++++++++++++
 tb/tb_lbdr_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_param.sv
// Parametrised LBDR routing unit for one NoC router input port; holds the route for a whole packet.
// Optional error/protocol monitor outputs are built when LBDR_ERR_CHECK_EN is defined.
module lbdr_param #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int FID_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               empty,
  input  logic               flit_rd,
  input  logic [FID_W-1:0]   flit_id,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic [X_W+Y_W-1:0] cur_addr_rst,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_Rxy,
  input  logic [3:0]         cfg_Cx,
  output logic               cfg_pending,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
`ifdef LBDR_ERR_CHECK_EN
  output logic               err_unroutable,
  output logic               err_proto,
  output logic [7:0]         err_count,
`endif
  output logic               route_valid
);

  localparam int ADDR_W = X_W + Y_W;
  localparam logic [FID_W-1:0] FID_HEADER = FID_W'(1);
  localparam logic [FID_W-1:0] FID_BODY   = FID_W'(2);
  localparam logic [FID_W-1:0] FID_TAIL   = FID_W'(4);

  typedef enum logic {S_IDLE, S_ROUTED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_rxy;
  logic [3:0]        r_cx;
  logic [ADDR_W-1:0] r_cur;
  logic [7:0]        r_sh_rxy;
  logic [3:0]        r_sh_cx;
  logic              r_pending;
  logic [4:0]        r_ports;   // {N,E,W,S,L}

  logic [X_W-1:0]    w_dx, w_cx_cur;
  logic [Y_W-1:0]    w_dy, w_cy_cur;
  logic              w_go_n, w_go_s, w_go_e, w_go_w;
  logic [4:0]        w_route;
  logic              w_hdr, w_tail_pop, w_accept_hdr, w_release;

  assign w_dx     = dst_addr[X_W-1:0];
  assign w_dy     = dst_addr[ADDR_W-1:X_W];
  assign w_cx_cur = r_cur[X_W-1:0];
  assign w_cy_cur = r_cur[ADDR_W-1:X_W];

  assign w_go_n = w_dy < w_cy_cur;
  assign w_go_s = w_dy > w_cy_cur;
  assign w_go_e = w_dx > w_cx_cur;
  assign w_go_w = w_dx < w_cx_cur;

  // Rxy bit order: [0]ne [1]nw [2]en [3]es [4]wn [5]ws [6]se [7]sw
  assign w_route[4] = r_cx[0] & w_go_n & ((~w_go_e & ~w_go_w) | (w_go_e & r_rxy[0]) | (w_go_w & r_rxy[1]));
  assign w_route[3] = r_cx[1] & w_go_e & ((~w_go_n & ~w_go_s) | (w_go_n & r_rxy[2]) | (w_go_s & r_rxy[3]));
  assign w_route[2] = r_cx[2] & w_go_w & ((~w_go_n & ~w_go_s) | (w_go_n & r_rxy[4]) | (w_go_s & r_rxy[5]));
  assign w_route[1] = r_cx[3] & w_go_s & ((~w_go_e & ~w_go_w) | (w_go_e & r_rxy[6]) | (w_go_w & r_rxy[7]));
  assign w_route[0] = ~w_go_n & ~w_go_e & ~w_go_w & ~w_go_s;

  assign w_hdr        = ~empty & (flit_id == FID_HEADER);
  assign w_tail_pop   = ~empty & flit_rd & (flit_id == FID_TAIL);
  assign w_accept_hdr = (r_state == S_IDLE) & w_hdr;
  assign w_release    = (r_state == S_ROUTED) & w_tail_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hdr)      w_state_nxt = S_ROUTED;
      S_ROUTED: if (w_tail_pop) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Config writes land directly only while idle with no header arriving; otherwise they wait in the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxy     <= Rxy_rst;
      r_cx      <= Cx_rst;
      r_cur     <= cur_addr_rst;
      r_ports   <= '0;
      r_pending <= 1'b0;
      r_sh_rxy  <= '0;
      r_sh_cx   <= '0;
    end else begin
      if (w_accept_hdr)   r_ports <= w_route;
      else if (w_release) r_ports <= '0;

      if (w_release) begin
        if (cfg_we) begin
          r_rxy <= cfg_Rxy;
          r_cx  <= cfg_Cx;
        end else if (r_pending) begin
          r_rxy <= r_sh_rxy;
          r_cx  <= r_sh_cx;
        end
        r_pending <= 1'b0;
      end else if (cfg_we) begin
        if ((r_state == S_IDLE) && !w_hdr) begin
          r_rxy <= cfg_Rxy;
          r_cx  <= cfg_Cx;
        end else begin
          r_sh_rxy  <= cfg_Rxy;
          r_sh_cx   <= cfg_Cx;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign Nport       = r_ports[4];
  assign Eport       = r_ports[3];
  assign Wport       = r_ports[2];
  assign Sport       = r_ports[1];
  assign Lport       = r_ports[0];
  assign route_valid = (r_state == S_ROUTED);
  assign cfg_pending = r_pending;

`ifdef LBDR_ERR_CHECK_EN
  logic w_ev_unr, w_ev_proto;

  assign w_ev_unr   = w_accept_hdr & (w_route == 5'b0);
  assign w_ev_proto = ~empty & (((r_state == S_ROUTED) & (flit_id == FID_HEADER)) |
                                ((r_state == S_IDLE) & ((flit_id == FID_BODY) | (flit_id == FID_TAIL))));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_unroutable <= 1'b0;
      err_proto      <= 1'b0;
      err_count      <= 8'h00;
    end else begin
      err_unroutable <= w_ev_unr;
      err_proto      <= w_ev_proto;
      if ((w_ev_unr | w_ev_proto) && (err_count != 8'hFF))
        err_count <= err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_lbdr_param.sv
// Randomised and directed bench for lbdr_param, checked against a packet-level reference model.
module tb_lbdr_param;
  localparam int X_W = 2;
  localparam int Y_W = 2;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, empty = 1'b1, flit_rd = 1'b0, cfg_we = 1'b0;
  logic [2:0] flit_id = BODY;
  logic [3:0] dst_addr = '0, cur_addr_rst = 4'b0101, Cx_rst = 4'hF, cfg_Cx = '0;
  logic [7:0] Rxy_rst = 8'hFF, cfg_Rxy = '0;
  logic       cfg_pending, Nport, Eport, Wport, Sport, Lport, route_valid;
`ifdef LBDR_ERR_CHECK_EN
  logic       err_unroutable, err_proto;
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  lbdr_param #(.X_W(X_W), .Y_W(Y_W), .FID_W(3)) dut (
    .clk(clk), .rst(rst), .empty(empty), .flit_rd(flit_rd), .flit_id(flit_id),
    .dst_addr(dst_addr), .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .cur_addr_rst(cur_addr_rst),
    .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx), .cfg_pending(cfg_pending),
    .Nport(Nport), .Eport(Eport), .Wport(Wport), .Sport(Sport), .Lport(Lport),
`ifdef LBDR_ERR_CHECK_EN
    .err_unroutable(err_unroutable), .err_proto(err_proto), .err_count(err_count),
`endif
    .route_valid(route_valid)
  );

  // Reference model: packet state, held route, live and deferred configuration.
  bit         m_routed = 0, m_pend = 0;
  logic [4:0] m_ports = '0;
  logic [7:0] m_rxy = '0, m_sh_rxy = '0;
  logic [3:0] m_cx = '0, m_sh_cx = '0, m_cur = '0;
  bit         m_eu = 0, m_ep = 0;
  int         m_cnt = 0;

  function automatic logic [4:0] ref_route(input logic [3:0] dst, input logic [3:0] cur,
                                           input logic [7:0] r, input logic [3:0] c);
    int dx, dy, cx, cy;
    bit go_n, go_s, go_e, go_w, horiz, vert, n, e, w, s, l;
    dx = int'(dst[X_W-1:0]);  dy = int'(dst[3:X_W]);
    cx = int'(cur[X_W-1:0]);  cy = int'(cur[3:X_W]);
    go_n = dy < cy; go_s = dy > cy; go_e = dx > cx; go_w = dx < cx;
    horiz = go_e || go_w; vert = go_n || go_s;
    n = c[0] && go_n && (!horiz || (go_e ? r[0] : r[1]));
    e = c[1] && go_e && (!vert  || (go_n ? r[2] : r[3]));
    w = c[2] && go_w && (!vert  || (go_n ? r[4] : r[5]));
    s = c[3] && go_s && (!horiz || (go_e ? r[6] : r[7]));
    l = !horiz && !vert;
    return {n, e, w, s, l};
  endfunction

  task automatic model_update();
    bit hdr, tp;
    logic [4:0] rt;
    if (rst) begin
      m_rxy = Rxy_rst; m_cx = Cx_rst; m_cur = cur_addr_rst;
      m_routed = 0; m_ports = '0; m_pend = 0; m_sh_rxy = '0; m_sh_cx = '0;
      m_eu = 0; m_ep = 0; m_cnt = 0;
    end else begin
      hdr = !empty && (flit_id == HDR);
      tp  = !empty && flit_rd && (flit_id == TAIL);
      rt  = ref_route(dst_addr, m_cur, m_rxy, m_cx);
      m_eu = !m_routed && hdr && (rt == 5'b0);
      m_ep = !empty && (m_routed ? (flit_id == HDR) : (flit_id == BODY || flit_id == TAIL));
      if ((m_eu || m_ep) && m_cnt < 255) m_cnt++;
      if (!m_routed) begin
        if (cfg_we && hdr) begin
          m_sh_rxy = cfg_Rxy; m_sh_cx = cfg_Cx; m_pend = 1;
        end else if (cfg_we) begin
          m_rxy = cfg_Rxy; m_cx = cfg_Cx;
        end
        if (hdr) begin m_routed = 1; m_ports = rt; end
      end else if (tp) begin
        m_routed = 0; m_ports = '0;
        if (cfg_we) begin m_rxy = cfg_Rxy; m_cx = cfg_Cx; end
        else if (m_pend) begin m_rxy = m_sh_rxy; m_cx = m_sh_cx; end
        m_pend = 0;
      end else if (cfg_we) begin
        m_sh_rxy = cfg_Rxy; m_sh_cx = cfg_Cx; m_pend = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic e, input logic rd, input logic [2:0] id, input logic [3:0] dst);
    empty = e; flit_rd = rd; flit_id = id; dst_addr = dst;
  endtask

  // {N,E,W,S,L,route_valid,cfg_pending}
  function automatic logic [6:0] dut_core();
    return {Nport, Eport, Wport, Sport, Lport, route_valid, cfg_pending};
  endfunction

  function automatic logic [6:0] mdl_core();
    return {m_ports, m_routed, m_pend};
  endfunction

  task automatic test_reset();
    rst = 1; drive(0, 1, HDR, 4'b0000);
    tick(); tick();
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b want %b", dut_core(), 7'b0); end
    checks++;
    if (dut_core() !== mdl_core()) begin errors++; $display("FAIL reset_model got %b want %b", dut_core(), mdl_core()); end
    rst = 0; drive(1, 0, BODY, 0);
  endtask

  task automatic test_local();
    Rxy_rst = 8'hFF; Cx_rst = 4'hF; cur_addr_rst = 4'b0101;
    rst = 1; drive(1, 0, BODY, 0); tick(); rst = 0;
    drive(0, 0, HDR, 4'b0101); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0000110) begin errors++; $display("FAIL local_L got %b want %b", dut_core(), 7'b0000110); end
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL local_release got %b want %b", dut_core(), 7'b0); end
  endtask

  task automatic test_hold_release();
    drive(0, 0, HDR, 4'b0001); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_core() !== 7'b1000010) begin errors++; $display("FAIL hold_N[%0d] got %b want %b", i, dut_core(), 7'b1000010); end
      drive(0, 0, (i == 1) ? TAIL : BODY, 4'b1111); tick();
    end
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL hold_release got %b want %b", dut_core(), 7'b0); end
  endtask

  task automatic test_adaptive();
    drive(0, 0, HDR, 4'b1010); tick();
    checks++;
    if (dut_core() !== 7'b0101010) begin errors++; $display("FAIL adaptive_ES got %b want %b", dut_core(), 7'b0101010); end
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    cfg_we = 1; cfg_Rxy = 8'h00; cfg_Cx = 4'hF; tick(); cfg_we = 0;
    drive(0, 0, HDR, 4'b1010); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0000010) begin errors++; $display("FAIL adaptive_blocked got %b want %b", dut_core(), 7'b0000010); end
`ifdef LBDR_ERR_CHECK_EN
    checks++;
    if (err_unroutable !== 1'b1) begin errors++; $display("FAIL adaptive_err_unr got %b want 1", err_unroutable); end
`endif
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    cfg_we = 1; cfg_Rxy = 8'hFF; cfg_Cx = 4'hF; tick(); cfg_we = 0;
  endtask

  task automatic test_deferred_cfg();
    drive(0, 0, HDR, 4'b1010); tick(); drive(1, 0, BODY, 0);
    cfg_we = 1; cfg_Rxy = 8'hFF; cfg_Cx = 4'b1110; tick(); cfg_we = 0;
    checks++;
    if (dut_core() !== 7'b0101011) begin errors++; $display("FAIL deferred_pending got %b want %b", dut_core(), 7'b0101011); end
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL deferred_commit got %b want %b", dut_core(), 7'b0); end
    drive(0, 0, HDR, 4'b0001); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0000010) begin errors++; $display("FAIL deferred_noN got %b want %b", dut_core(), 7'b0000010); end
`ifdef LBDR_ERR_CHECK_EN
    checks++;
    if (err_unroutable !== 1'b1) begin errors++; $display("FAIL deferred_err_unr got %b want 1", err_unroutable); end
`endif
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
    cfg_we = 1; cfg_Cx = 4'hF; tick(); cfg_we = 0;
  endtask

  task automatic test_reset_mid();
    drive(0, 0, HDR, 4'b0110); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0100010) begin errors++; $display("FAIL midrst_E got %b want %b", dut_core(), 7'b0100010); end
    rst = 1; tick(); rst = 0;
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL midrst_clear got %b want %b", dut_core(), 7'b0); end
    drive(0, 0, BODY, 4'b0110); tick();
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL midrst_body got %b want %b", dut_core(), 7'b0); end
`ifdef LBDR_ERR_CHECK_EN
    checks++;
    if (err_proto !== 1'b1) begin errors++; $display("FAIL midrst_err_proto got %b want 1", err_proto); end
`endif
    drive(0, 1, TAIL, 4'b0110); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL midrst_tail got %b want %b", dut_core(), 7'b0); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, HDR, 4'b0100); tick();
    drive(0, 1, TAIL, 0); tick();
    checks++;
    if (dut_core() !== 7'b0) begin errors++; $display("FAIL b2b_release got %b want %b", dut_core(), 7'b0); end
    drive(0, 0, HDR, 4'b1101); tick(); drive(1, 0, BODY, 0);
    checks++;
    if (dut_core() !== 7'b0001010) begin errors++; $display("FAIL b2b_second got %b want %b", dut_core(), 7'b0001010); end
    checks++;
    if (dut_core() !== mdl_core()) begin errors++; $display("FAIL b2b_model got %b want %b", dut_core(), mdl_core()); end
    drive(0, 1, TAIL, 0); tick(); drive(1, 0, BODY, 0);
  endtask

  task automatic test_random();
    logic [2:0] ids [4] = '{HDR, BODY, TAIL, 3'b000};
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (rst) begin Rxy_rst = 8'($urandom); Cx_rst = 4'($urandom); cur_addr_rst = 4'($urandom); end
      drive($urandom_range(0, 3) == 0, 1'($urandom), ids[$urandom_range(0, 3)], 4'($urandom));
      cfg_we = ($urandom_range(0, 7) == 0); cfg_Rxy = 8'($urandom); cfg_Cx = 4'($urandom);
      tick();
      checks++;
      if (dut_core() !== mdl_core()) begin
        errors++; $display("FAIL random_core[%0d] got %b want %b", i, dut_core(), mdl_core());
      end
`ifdef LBDR_ERR_CHECK_EN
      checks++;
      if ({err_unroutable, err_proto, err_count} !== {m_eu, m_ep, 8'(m_cnt)}) begin
        errors++; $display("FAIL random_err[%0d] got %b want %b", i, {err_unroutable, err_proto, err_count}, {m_eu, m_ep, 8'(m_cnt)});
      end
`endif
    end
    rst = 0; cfg_we = 0; drive(1, 0, BODY, 0);
  endtask

`ifdef LBDR_ERR_CHECK_EN
  task automatic test_err_saturation();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 300; i++) begin drive(0, 0, BODY, 4'($urandom)); tick(); end
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_count got %h want ff", err_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h want ff", err_count); end
    rst = 1; tick(); rst = 0; drive(1, 0, BODY, 0);
    checks++;
    if (err_count !== 8'h00) begin errors++; $display("FAIL sat_reset got %h want 00", err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_local();
    test_hold_release();
    test_adaptive();
    test_deferred_cfg();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef LBDR_ERR_CHECK_EN
    test_err_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
